// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment frame capture block: active-low
// segment patterns (bit6=g .. bit0=a), special digit codes and FSM states.
package seg7_pkg;

   localparam logic [6:0] PAT_0     = 7'b1000000;
   localparam logic [6:0] PAT_1     = 7'b1111001;
   localparam logic [6:0] PAT_2     = 7'b0100100;
   localparam logic [6:0] PAT_3     = 7'b0110000;
   localparam logic [6:0] PAT_4     = 7'b0011001;
   localparam logic [6:0] PAT_5     = 7'b0010010;
   localparam logic [6:0] PAT_6     = 7'b0000010;
   localparam logic [6:0] PAT_7     = 7'b1111000;
   localparam logic [6:0] PAT_8     = 7'b0000000;
   localparam logic [6:0] PAT_9     = 7'b0010000;
   localparam logic [6:0] PAT_E     = 7'b0000110;
   localparam logic [6:0] PAT_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_E     = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_pattern_to_code.sv
// Combinational decode of an active-low segment pattern to a 4-bit digit
// code. Unknown patterns decode to CODE_BLANK with o_err raised.
module seg7_pattern_to_code
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg_n,
   output logic [3:0] o_code,
   output logic       o_err
);

   // Pattern lookup; blank is a legal pattern and shares the code of errors.
   always_comb begin
      o_code = CODE_BLANK;
      o_err  = 1'b0;
      unique case (i_seg_n)
         PAT_0:     o_code = 4'h0;
         PAT_1:     o_code = 4'h1;
         PAT_2:     o_code = 4'h2;
         PAT_3:     o_code = 4'h3;
         PAT_4:     o_code = 4'h4;
         PAT_5:     o_code = 4'h5;
         PAT_6:     o_code = 4'h6;
         PAT_7:     o_code = 4'h7;
         PAT_8:     o_code = 4'h8;
         PAT_9:     o_code = 4'h9;
         PAT_E:     o_code = CODE_E;
         PAT_BLANK: o_code = CODE_BLANK;
         default:   o_err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_frame_capture.sv
// Reader for a multiplexed active-low seven-segment bus. Each digit position
// must show the same pattern for STABLE_CNT qualified samples before it is
// accepted; once every position has been accepted the frame is offered on a
// valid/ready output.
// Optional build macro SEG7_CHANGE_ONLY_EN: drop completed frames that equal
// the last presented frame (first frame after reset is always presented).
module seg7_frame_capture
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned STABLE_CNT = 3,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_sample_en,
   input  logic [NUM_DIGITS-1:0]   i_an_n,
   input  logic [6:0]              i_seg_n,
   output logic [4*NUM_DIGITS-1:0] o_frame_data,
   output logic [NUM_DIGITS-1:0]   o_frame_err,
   output logic                    o_frame_valid,
   input  logic                    i_frame_ready,
   output logic                    o_glitch
);

   localparam logic [CNT_W-1:0] CntMax   = '1;
   localparam logic [CNT_W-1:0] StableM1 = CNT_W'(STABLE_CNT - 1);

   logic [NUM_DIGITS-1:0]   w_an;
   logic [NUM_DIGITS-1:0]   w_hit_mask;
   logic [NUM_DIGITS-1:0]   w_seen_d;
   logic [NUM_DIGITS-1:0]   r_prev_an;
   logic [NUM_DIGITS-1:0]   r_seen;
   logic [NUM_DIGITS-1:0]   r_slot_err;
   logic [NUM_DIGITS-1:0]   r_frame_err;
   logic [4*NUM_DIGITS-1:0] r_slot_code;
   logic [4*NUM_DIGITS-1:0] r_frame_data;
   logic [6:0]              r_prev_seg;
   logic [CNT_W-1:0]        r_cnt;
   logic [3:0]              w_code;
   logic                    w_err;
   logic                    w_onehot;
   logic                    w_bad_an;
   logic                    w_qual;
   logic                    w_same;
   logic                    w_hit;
   logic                    w_free;
   logic                    w_load;
   logic                    w_accept_en;
   logic                    w_dup;
   logic                    r_glitch;
   logic                    r_frame_valid;
   state_t                  r_state;
   state_t                  w_state_d;

   seg7_pattern_to_code u_decode (
      .i_seg_n (i_seg_n),
      .o_code  (w_code),
      .o_err   (w_err)
   );

   assign w_an     = ~i_an_n;
   assign w_onehot = ($countones(w_an) == 1);
   assign w_bad_an = i_sample_en && !w_onehot;
   assign w_qual   = i_sample_en && w_onehot;
   assign w_same   = (i_an_n == r_prev_an) && (i_seg_n == r_prev_seg);
   // Fire exactly on the sample that brings the run length up to STABLE_CNT.
   assign w_hit    = w_qual && (w_same ? (r_cnt == StableM1) : (STABLE_CNT == 1));
   assign w_hit_mask = w_hit ? w_an : '0;
   // Output register can take a new frame when empty or being drained now.
   assign w_free   = !r_frame_valid || i_frame_ready;

`ifdef SEG7_CHANGE_ONLY_EN
   logic r_presented;

   // Remember whether any frame has been shown since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presented <= 1'b0;
      end else if (w_load) begin
         r_presented <= 1'b1;
      end
   end

   assign w_dup = r_presented && ({r_slot_code, r_slot_err} == {r_frame_data, r_frame_err});
`else
   assign w_dup = 1'b0;
`endif

   // Stability tracker: previous qualified sample, run counter, glitch pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_an  <= '1;
         r_prev_seg <= '1;
         r_cnt      <= '0;
         r_glitch   <= 1'b0;
      end else begin
         r_glitch <= w_bad_an;
         if (w_bad_an) begin
            r_cnt <= '0;
         end else if (w_qual) begin
            if (w_same) begin
               if (r_cnt != CntMax) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end else begin
               r_prev_an  <= i_an_n;
               r_prev_seg <= i_seg_n;
               r_cnt      <= CNT_W'(1);
            end
         end
      end
   end

   // Next-state logic: collect until all digits seen, then hand off when free.
   always_comb begin
      w_state_d   = r_state;
      w_seen_d    = r_seen;
      w_load      = 1'b0;
      w_accept_en = 1'b0;
      unique case (r_state)
         COLLECT: begin
            w_accept_en = 1'b1;
            w_seen_d    = r_seen | w_hit_mask;
            if (w_seen_d == '1) begin
               w_state_d = PRESENT;
            end
         end
         PRESENT: begin
            // While the previous frame is still pending, accepts are dropped.
            if (w_free) begin
               w_load      = 1'b1;
               w_accept_en = 1'b1;
               w_seen_d    = w_hit_mask;
               w_state_d   = (w_seen_d == '1) ? PRESENT : COLLECT;
            end
         end
      endcase
   end

   // FSM state and seen mask.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= COLLECT;
         r_seen  <= '0;
      end else begin
         r_state <= w_state_d;
         r_seen  <= w_seen_d;
      end
   end

   // Digit slots; a re-accepted digit overwrites its slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot_code <= '0;
         r_slot_err  <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_accept_en && w_hit_mask[i]) begin
               r_slot_code[4*i +: 4] <= w_code;
               r_slot_err[i]         <= w_err;
            end
         end
      end
   end

   // Output register with valid/ready hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_data  <= '0;
         r_frame_err   <= '0;
         r_frame_valid <= 1'b0;
      end else if (w_load && !w_dup) begin
         r_frame_data  <= r_slot_code;
         r_frame_err   <= r_slot_err;
         r_frame_valid <= 1'b1;
      end else if (i_frame_ready) begin
         r_frame_valid <= 1'b0;
      end
   end

   assign o_frame_data  = r_frame_data;
   assign o_frame_err   = r_frame_err;
   assign o_frame_valid = r_frame_valid;
   assign o_glitch      = r_glitch;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Self-checking bench for seg7_frame_capture: directed scenarios followed by
// randomized bus activity, all checked every cycle against a behavioural model.
module tb_seg7_frame_capture;

   localparam int ND = 4;
   localparam int SC = 3;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            sample_en;
   logic [ND-1:0]   an_n;
   logic [6:0]      seg_n;
   logic [4*ND-1:0] frame_data;
   logic [ND-1:0]   frame_err;
   logic            frame_valid;
   logic            frame_ready;
   logic            glitch;

   always #5 clk = ~clk;

   seg7_frame_capture #(
      .NUM_DIGITS (ND),
      .STABLE_CNT (SC),
      .CNT_W      (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_sample_en   (sample_en),
      .i_an_n        (an_n),
      .i_seg_n       (seg_n),
      .o_frame_data  (frame_data),
      .o_frame_err   (frame_err),
      .o_frame_valid (frame_valid),
      .i_frame_ready (frame_ready),
      .o_glitch      (glitch)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [6:0] pat_tab [16];

   // Behavioural model state.
   logic [ND-1:0]   m_prev_an;
   logic [6:0]      m_prev_seg;
   int              m_run;
   logic [ND-1:0]   m_seen;
   logic [3:0]      m_code [ND];
   logic            m_err  [ND];
   bit              m_complete;
   bit              m_shown;
   logic [4*ND-1:0] m_data;
   logic [ND-1:0]   m_ferr;
   bit              m_valid;
   bit              m_glitch;

   // Handshakes seen on the DUT output.
   int              obs_taken = 0;
   logic [4*ND-1:0] obs_last_data;
   logic [ND-1:0]   obs_last_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void decode(input logic [6:0] p, output logic [3:0] c, output logic e);
      c = 4'hF;
      e = (p != 7'h7F);
      for (int i = 0; i < 16; i++) begin
         if ((i < 10 || i == 14) && pat_tab[i] == p) begin
            c = 4'(i);
            e = 1'b0;
         end
      end
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      logic [ND-1:0]   act;
      logic [4*ND-1:0] nd;
      logic [ND-1:0]   ne;
      logic [3:0]      c;
      logic            e;
      bit              hit, free, present, dup;
      int              pos;
      if (reset) begin
         m_prev_an  = '1;
         m_prev_seg = '1;
         m_run      = 0;
         m_seen     = '0;
         m_complete = 0;
         m_shown    = 0;
         m_data     = '0;
         m_ferr     = '0;
         m_valid    = 0;
         m_glitch   = 0;
         return;
      end
      act      = ~an_n;
      free     = !m_valid || frame_ready;
      m_glitch = sample_en && ($countones(act) != 1);
      hit      = 0;
      present  = 0;
      pos      = 0;
      nd       = '0;
      ne       = '0;
      for (int i = 0; i < ND; i++) if (act[i]) pos = i;
      if (m_glitch) begin
         m_run = 0;
      end else if (sample_en) begin
         if (an_n == m_prev_an && seg_n == m_prev_seg) begin
            hit = (m_run + 1 == SC);
            if (m_run < (1 << CW) - 1) m_run++;
         end else begin
            m_prev_an  = an_n;
            m_prev_seg = seg_n;
            m_run      = 1;
            hit        = (SC == 1);
         end
      end
      if (m_complete) begin
         if (free) begin
            present = 1;
            for (int i = 0; i < ND; i++) begin
               nd[4*i +: 4] = m_code[i];
               ne[i]        = m_err[i];
            end
            m_seen     = '0;
            m_complete = 0;
         end else begin
            hit = 0;
         end
      end
      if (hit) begin
         decode(seg_n, c, e);
         m_code[pos]  = c;
         m_err[pos]   = e;
         m_seen[pos]  = 1'b1;
         if (m_seen == '1) m_complete = 1;
      end
`ifdef SEG7_CHANGE_ONLY_EN
      dup = m_shown && nd == m_data && ne == m_ferr;
`else
      dup = 0;
`endif
      if (present && !dup) begin
         m_data  = nd;
         m_ferr  = ne;
         m_valid = 1;
         m_shown = 1;
      end else if (frame_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic tick();
      if (frame_valid && frame_ready) begin
         obs_taken++;
         obs_last_data = frame_data;
         obs_last_err  = frame_err;
      end
      @(posedge clk);
      model_step();
      #1;
      chk("valid", 32'(frame_valid), 32'(m_valid));
      chk("data", 32'(frame_data), 32'(m_data));
      chk("err", 32'(frame_err), 32'(m_ferr));
      chk("glitch", 32'(glitch), 32'(m_glitch));
   endtask

   task automatic drive_digit(input int pos, input logic [6:0] pat, input int n);
      logic [ND-1:0] b;
      b         = 1;
      an_n      = ~(b << pos);
      seg_n     = pat;
      sample_en = 1'b1;
      repeat (n) tick();
   endtask

   task automatic drive_frame(input logic [15:0] codes);
      for (int i = 0; i < ND; i++) drive_digit(i, pat_tab[codes[4*i +: 4]], SC);
   endtask

   task automatic idle(input int n);
      sample_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample_en = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   initial begin
      int t0;
      pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
                  7'h7F, 7'h7F, 7'b0000110, 7'b1111111};
      reset       = 1'b1;
      sample_en   = 1'b0;
      an_n        = '1;
      seg_n       = '1;
      frame_ready = 1'b1;
      do_reset();
      chk("reset_data", 32'(frame_data), 32'h0);
      chk("reset_valid", 32'(frame_valid), 32'h0);

      // Plain frame.
      t0 = obs_taken;
      drive_frame(16'h4321);
      idle(4);
      chk("f1_count", 32'(obs_taken - t0), 32'd1);
      chk("f1_data", 32'(obs_last_data), 32'h4321);
      chk("f1_err", 32'(obs_last_err), 32'h0);

      // Digit 2 too short, then re-driven.
      t0 = obs_taken;
      drive_digit(0, pat_tab[1], 3);
      drive_digit(1, pat_tab[2], 2);
      drive_digit(2, pat_tab[3], 3);
      drive_digit(3, pat_tab[4], 3);
      idle(4);
      chk("short_count", 32'(obs_taken - t0), 32'd0);
      drive_digit(1, pat_tab[2], 3);
      idle(4);
      chk("redrive_count", 32'(obs_taken - t0), 32'd1);
      chk("redrive_data", 32'(obs_last_data), 32'h4321);

      // Unknown pattern and blank.
      drive_digit(0, 7'b1010101, 3);
      drive_digit(1, pat_tab[8], 3);
      drive_digit(2, pat_tab[8], 3);
      drive_digit(3, pat_tab[8], 3);
      idle(4);
      chk("bad_data", 32'(obs_last_data), 32'h888F);
      chk("bad_err", 32'(obs_last_err), 32'h1);
      drive_frame(16'h88F8);
      idle(4);
      chk("blank_data", 32'(obs_last_data), 32'h88F8);
      chk("blank_err", 32'(obs_last_err), 32'h0);

      // Two active anodes.
      drive_digit(0, pat_tab[5], 2);
      an_n = 4'b1100;
      tick();
      chk("glitch_pulse", 32'(glitch), 32'h1);
      drive_digit(0, pat_tab[5], 1);
      idle(2);
      chk("glitch_drop", 32'(glitch), 32'h0);

      // Back-pressure while a second frame completes.
      do_reset();
      frame_ready = 1'b0;
      t0 = obs_taken;
      drive_frame(16'h4321);
      idle(2);
      drive_frame(16'h8765);
      idle(6);
      chk("hold_data", 32'(frame_data), 32'h4321);
      chk("hold_valid", 32'(frame_valid), 32'h1);
      frame_ready = 1'b1;
      tick();
      chk("next_data", 32'(frame_data), 32'h8765);
      chk("next_valid", 32'(frame_valid), 32'h1);
      idle(3);
      chk("bp_count", 32'(obs_taken - t0), 32'd2);

      // Randomized bus traffic.
      for (int k = 0; k < 150; k++) begin
         int hold, cl, code, pos;
         logic [ND-1:0] b;
         hold = $urandom_range(1, 5);
         pos  = $urandom_range(0, ND - 1);
         cl   = $urandom_range(0, 11);
         code = (cl < 10) ? cl : ((cl == 10) ? 14 : 15);
         b    = 1;
         an_n  = ~(b << pos);
         seg_n = pat_tab[code];
         if ($urandom_range(0, 9) == 0) an_n = ND'($urandom);
         if ($urandom_range(0, 9) == 0) seg_n = 7'($urandom);
         repeat (hold) begin
            sample_en   = ($urandom_range(0, 4) != 0);
            frame_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      // Repeated frame, then a changed one.
      frame_ready = 1'b1;
      do_reset();
      t0 = obs_taken;
      drive_frame(16'h1234);
      idle(3);
      drive_frame(16'h1234);
      idle(3);
      drive_frame(16'h1235);
      idle(3);
`ifdef SEG7_CHANGE_ONLY_EN
      chk("repeat_count", 32'(obs_taken - t0), 32'd2);
`else
      chk("repeat_count", 32'(obs_taken - t0), 32'd3);
`endif
      chk("repeat_last", 32'(obs_last_data), 32'h1235);

      // Reset in the middle of a frame discards it.
      t0 = obs_taken;
      drive_digit(0, pat_tab[7], 3);
      drive_digit(1, pat_tab[6], 3);
      do_reset();
      chk("midrst_data", 32'(frame_data), 32'h0);
      chk("midrst_valid", 32'(frame_valid), 32'h0);
      drive_digit(2, pat_tab[5], 3);
      drive_digit(3, pat_tab[4], 3);
      idle(4);
      chk("midrst_count", 32'(obs_taken - t0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
